// File: rtl/high_pass_filter_pkg.sv
// Shared definitions for the high-pass filter and its sibling low-pass stage.
package hpf_pkg;

    localparam int W_DEFAULT = 20;

    localparam logic signed [W_DEFAULT-1:0] SAT_MAX = {1'b0, {(W_DEFAULT-1){1'b1}}};
    localparam logic signed [W_DEFAULT-1:0] SAT_MIN = {1'b1, {(W_DEFAULT-1){1'b0}}};

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } hpf_state_t;

endpackage

// File: rtl/high_pass_filter_sample_edge_detect.sv
// Turns the slow sample strobe into a single-cycle event on its rising edge.
// History resets to 1 so a strobe held high through reset release is ignored.
module sample_edge_detect (
    input  logic qzt_clk,
    input  logic rst_n,
    input  logic clk_in,
    output logic sample_evt
);

    logic clk_in_old;

    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_in_old <= 1'b1;
        end else begin
            clk_in_old <= clk_in;
        end
    end

    assign sample_evt = clk_in & ~clk_in_old;

endmodule

// File: rtl/high_pass_filter.sv
// First-order IIR high-pass: Vout = x - lp, lp tracking x with time constant 2^k samples.
// Define HPF_SATURATE_EN to clamp Vout on overflow instead of wrapping.
module high_pass_filter
    import hpf_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic                qzt_clk,
    input  logic                rst_n,
    input  logic                clk_in,
    input  logic [3:0]          k,
    input  logic signed [W-1:0] Vin,
    output logic signed [W-1:0] Vout,
    output logic                out_valid,
    output logic                settled
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                sample_evt;
    logic                v1;
    logic                v2;
    logic signed [W-1:0] x_r;
    logic signed [W-1:0] x_d;
    logic signed [W-1:0] lp;
    logic signed [W-1:0] lp_next;
    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] lp_sh;
    logic signed [W-1:0] vout_next;
    logic [3:0]          k_r;
    logic [3:0]          k_prev;
    logic [3:0]          k_prev_next;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_next;
    logic [CNT_W-1:0]    count_inc;
    logic [CNT_W-1:0]    target;
    hpf_state_t          state;
    hpf_state_t          state_next;

    sample_edge_detect u_edge (
        .qzt_clk    (qzt_clk),
        .rst_n      (rst_n),
        .clk_in     (clk_in),
        .sample_evt (sample_evt)
    );

    // Low-pass update wraps modulo 2^W; for in-range lp the true result always fits.
    assign x_sh    = x_r >>> k_r;
    assign lp_sh   = lp >>> k_r;
    assign lp_next = lp + x_sh - lp_sh;

`ifdef HPF_SATURATE_EN
    localparam logic signed [W-1:0] OUT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] OUT_MIN = {1'b1, {(W-1){1'b0}}};

    logic signed [W:0] diff;

    assign diff = {x_d[W-1], x_d} - {lp[W-1], lp};

    always_comb begin
        vout_next = diff[W-1:0];
        if (diff[W] != diff[W-1]) begin
            vout_next = diff[W] ? OUT_MIN : OUT_MAX;
        end
    end
`else
    assign vout_next = x_d - lp;
`endif

    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r       <= '0;
            k_r       <= '0;
            v1        <= 1'b0;
            lp        <= '0;
            x_d       <= '0;
            v2        <= 1'b0;
            Vout      <= '0;
            out_valid <= 1'b0;
        end else begin
            v1 <= sample_evt;
            if (sample_evt) begin
                x_r <= Vin;
                k_r <= k;
            end
            v2 <= v1;
            if (v1) begin
                lp  <= lp_next;
                x_d <= x_r;
            end
            out_valid <= v2;
            if (v2) begin
                Vout <= vout_next;
            end
        end
    end

    assign count_inc = count + ONE;
    assign target    = ONE << k_r;

    // A k change restarts settling and outranks the ordinary warm-up count.
    always_comb begin
        state_next  = state;
        count_next  = count;
        k_prev_next = k_prev;
        if (v1) begin
            k_prev_next = k_r;
            if (k_r != k_prev) begin
                count_next = ONE;
                if (target == ONE) begin
                    state_next = RUN;
                end else begin
                    state_next = WARMUP;
                end
            end else if (state == WARMUP) begin
                count_next = count_inc;
                if (count_inc == target) begin
                    state_next = RUN;
                end
            end
        end
    end

    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WARMUP;
            count   <= '0;
            k_prev  <= '0;
            settled <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            k_prev  <= k_prev_next;
            settled <= (state_next == RUN);
        end
    end

endmodule

// File: doc/high_pass_filter.md
Name: high_pass_filter

Overview:
- First-order IIR high-pass filter, the complementary path to the lab's existing low-pass stage.
- Runs on `qzt_clk`. Samples `Vin` on each rising edge of the slow sample strobe `clk_in`.
- Output is y[n] = x[n] − lp[n], where lp[n] = lp[n−1] + (x[n]>>>k) − (lp[n−1]>>>k).
- Three-stage pipeline feeding the DAC path; adds a settling FSM and an output-valid strobe.

Parameters:
- `W`, 20, sample width (signed, two's complement).
- `CNT_W`, 16, width of the settling sample counter (must exceed 15 so 2^15 fits).

Ports:
- `qzt_clk`  in  1  system quartz clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clk_in`  in  1  sample strobe, already synchronous to `qzt_clk`; sample taken on its rising edge.
- `k`  in  4  shift amount (time constant 2^k samples); latched per sample.
- `Vin`  in  W  signed input sample.
- `Vout`  out  W  signed high-pass output (registered).
- `out_valid`  out  1  one-cycle pulse when `Vout` updates.
- `settled`  out  1  level: filter has processed ≥ 2^k samples since reset or since the last k change.

Behaviour:
- Reset (async, `rst_n`=0): `Vout`=0, `out_valid`=0, `settled`=0, lp=0, pipeline valids=0, counter=0, FSM=WARMUP, `clk_in_old`=1. Resetting `clk_in_old` to 1 means a strobe held high through reset release produces no sample.
- Edge detect: sample event S at a posedge where `clk_in`=1 and `clk_in_old`=0; `clk_in_old` <= `clk_in` every cycle.
- Cycle E (event S): `x_r` <= `Vin`, `k_r` <= `k`, `v1` <= 1.
- Cycle E+1 (`v1`):
  - lp <= lp + (`x_r`>>>`k_r`) − (lp>>>`k_r`), computed in W+1 bits and truncated to W (cannot overflow for in-range lp).
  - `x_d` <= `x_r`, `lp_old` <= lp, `v2` <= 1.
- Cycle E+2 (`v2`): diff = `x_d` − lp_new in W+1 bits; `Vout` <= fit(diff); `out_valid` <= 1 for exactly one cycle. Latency from S to `Vout` visible: 3 posedges.
- All shifts are arithmetic (`>>>`) on signed operands; negative values round toward −∞.
- k=0: lp = x and `Vout` = 0.
- Strobe spacing: S events are at least 2 cycles apart. The pipeline accepts one sample per cycle, so no stall or drop is possible.
- Settling FSM:
  - WARMUP: counter increments at E+1 of each sample. When counter+1 == (1<<`k_r`): go to RUN, `settled` <= 1.
  - RUN: `settled` stays 1.
  - Any state: if `k_r` at E+1 differs from the `k_r` of the previous sample, counter <= 1 and state <= WARMUP, `settled` <= 0. If 1<<`k_r` == 1, go directly to RUN. The k-change check takes priority over the count check.
- `out_valid` pulses in both states; `settled` is informational only.
- Reset mid-pipeline: in-flight samples are discarded, no `out_valid` is produced, and all state returns to reset values.

Optional Feature:
- Macro `HPF_SATURATE_EN`.
  - Defined: fit() clamps diff to [−524288, +524287].
  - Undefined: fit() takes diff[W−1:0] (wrap-around); no extra logic.

Decomposition:
- Shared package `hpf_pkg` holds:
  - W_DEFAULT=20
  - SAT_MAX / SAT_MIN constants
  - FSM state encoding: WARMUP=1'b0, RUN=1'b1
- One natural sub-module: `sample_edge_detect` (`clk_in` → single-cycle event, reset-to-1 history register), reusable by the low-pass stage.

Test Plan:
- DC step, k=2, `Vin` 0→100000 after reset:
  - `Vout` = 75000, 56250, 42187 on successive samples.
  - Each `out_valid` pulse occurs at E+2.
  - `settled` rises at E+1 of the 4th sample.
- k=0, `Vin`=12345 repeated: `Vout`=0 every sample; `settled`=1 after the first sample.
- Saturation, k=4: drive `Vin`=−524288 for 400 samples, then `Vin`=+524287.
  - With `HPF_SATURATE_EN`: `Vout`=+524287.
  - Without: `Vout` is negative (wrapped).
- k change 2→3 after settling: `settled` drops at E+1 of the first k=3 sample and re-rises at E+1 of the 8th k=3 sample.
- `rst_n` pulsed low for 1 cycle at E+1: no `out_valid`; `Vout`=0 and lp=0 immediately (asynchronous); the next sample behaves as the first after reset.
- `clk_in` held high across reset release: no `out_valid` until `clk_in` goes low then high; the first output then appears 3 posedges after that edge.
